control_fsm: RTL and testbench

Multicycle control unit for the RV32 subset core (LW, SW, BEQ, register-register ALU, register-immediate ALU). It sequences every instruction through fetch/decode/execute/memory/write-back states. It drives the control inputs of the datapath: PC load and source, ALU source and operation, register write, write-back select. It also drives the data-memory strobes and a retired-instruction counter. It sits directly upstream of the datapath and consumes the datapath's `Zero` flag.

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/control_fsm_if.sv | 30 +++
 rtl/alu_decoder.sv | 41 ++++
 rtl/control_fsm.sv | 111 +++++++++++
 tb/tb_control_fsm.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32 subset control unit:
// opcodes, ALU operation codes, FSM states and the registered control bundle.
package ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_RR  = 7'b0110011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [2:0] {
        ST_IF,
        ST_ID,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_ILL
    } state_t;

    typedef struct packed {
        logic       load_pc;
        logic       pc_src;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_IMM) ||
               (op == OP_BEQ) || (op == OP_RR);
    endfunction

    function automatic logic op_mem(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic op_imm_src(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_IMM);
    endfunction

    function automatic logic op_writes(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_RR) || (op == OP_IMM);
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control-unit <-> datapath bundle: instruction word and Zero flag in,
// datapath/memory control strobes and retire counter out.
interface control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             Zero;
    logic             loadPC;
    logic             PCSrc;
    logic             ALUSrc;
    logic [3:0]       ALUCtrl;
    logic             RegWrite;
    logic             MemToReg;
    logic             MemRead;
    logic             MemWrite;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr, Zero,
        output loadPC, PCSrc, ALUSrc, ALUCtrl, RegWrite, MemToReg,
        output MemRead, MemWrite, illegal, retired
    );

    modport slave (
        output instr, Zero,
        input  loadPC, PCSrc, ALUSrc, ALUCtrl, RegWrite, MemToReg,
        input  MemRead, MemWrite, illegal, retired
    );
endinterface

// File: rtl/alu_decoder.sv
// Pure combinational ALU-operation decode from opcode/funct3/funct7[5];
// kept separate so a later pipelined control can reuse it.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctrl
);
    logic [3:0] fn_ctrl;
    logic       is_rr;

    assign is_rr = (opcode == OP_RR);

    // funct3 table shared by RR and IMM; only RR may turn 000 into SUB
    always_comb begin
        fn_ctrl = ALU_ADD;
        case (funct3)
            3'b000:  fn_ctrl = (is_rr && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  fn_ctrl = ALU_SLL;
            3'b010:  fn_ctrl = ALU_SLT;
            3'b100:  fn_ctrl = ALU_XOR;
            3'b101:  fn_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  fn_ctrl = ALU_OR;
            3'b111:  fn_ctrl = ALU_AND;
            default: fn_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (1'b1)
            (opcode == OP_BEQ): alu_ctrl = ALU_SUB;
            (opcode == OP_RR):  alu_ctrl = fn_ctrl;
            (opcode == OP_IMM): alu_ctrl = fn_ctrl;
            default:            alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM (IF/ID/EX/MEM/WB/ILL) with Moore-registered
// datapath strobes and a retired-instruction counter.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = ST_IF,
    parameter int     CNT_W       = 32
) (
    input  logic          clk,
    input  logic          rst,
    control_fsm_if.master bus
);
    state_t           state;
    state_t           nxt;
    logic [31:0]      ir;
    logic [31:0]      ir_d;
    logic             zero_q;
    logic             zero_d;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       op;
    logic [2:0]       f3;
    logic             f7_5;
    logic [3:0]       alu_op;
    logic             unused_ir;

    // Outputs are registered from the next state, so decode must look at
    // the word being latched this edge while still in IF.
    assign ir_d   = (state == ST_IF) ? bus.instr : ir;
    assign zero_d = (state == ST_EX) ? bus.Zero : zero_q;

    assign op        = ir_d[6:0];
    assign f3        = ir_d[14:12];
    assign f7_5      = ir_d[30];
    assign unused_ir = ^{ir_d[31], ir_d[29:15], ir_d[11:7]};

    alu_decoder u_dec (
        .opcode   (op),
        .funct3   (f3),
        .funct7_5 (f7_5),
        .alu_ctrl (alu_op)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IF:   nxt = ST_ID;
            ST_ID:   nxt = op_legal(op) ? ST_EX : ST_ILL;
            ST_EX:   nxt = op_mem(op) ? ST_MEM : ST_WB;
            ST_MEM:  nxt = ST_WB;
            ST_WB:   nxt = ST_IF;
            ST_ILL:  nxt = ST_ILL;
            default: nxt = ST_IF;
        endcase
    end

    always_comb begin
        ctrl_d = '0;
        case (nxt)
            ST_ID, ST_EX, ST_MEM, ST_WB: begin
                ctrl_d.alu_ctrl = alu_op;
                ctrl_d.alu_src  = op_imm_src(op);
            end
            default: ;
        endcase
        if (nxt == ST_MEM) begin
            ctrl_d.mem_read  = (op == OP_LW);
            ctrl_d.mem_write = (op == OP_SW);
        end
        if (nxt == ST_WB) begin
            ctrl_d.load_pc    = 1'b1;
            ctrl_d.pc_src     = (op == OP_BEQ) && zero_d;
            ctrl_d.reg_write  = op_writes(op);
            ctrl_d.mem_to_reg = (op == OP_LW);
        end
        if (nxt == ST_ILL) begin
            ctrl_d.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RESET_STATE;
            ir     <= '0;
            zero_q <= 1'b0;
            ctrl_q <= '0;
            cnt    <= '0;
        end else begin
            state  <= nxt;
            ir     <= ir_d;
            zero_q <= zero_d;
            ctrl_q <= ctrl_d;
            if (state == ST_WB) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.loadPC   = ctrl_q.load_pc;
    assign bus.PCSrc    = ctrl_q.pc_src;
    assign bus.ALUSrc   = ctrl_q.alu_src;
    assign bus.ALUCtrl  = ctrl_q.alu_ctrl;
    assign bus.RegWrite = ctrl_q.reg_write;
    assign bus.MemToReg = ctrl_q.mem_to_reg;
    assign bus.MemRead  = ctrl_q.mem_read;
    assign bus.MemWrite = ctrl_q.mem_write;
    assign bus.illegal  = ctrl_q.illegal;
    assign bus.retired  = cnt;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: instruction vector table plus
// reset, illegal-opcode and counter-wrap sequences.
module tb_control_fsm;
    import ctrl_pkg::*;

    localparam int CNT_W = 4;

    typedef struct {
        logic [31:0] instr;
        logic        zex;
        logic        zoth;
        logic [3:0]  alu;
        logic        src;
        logic        rd;
        logic        wr;
        logic        rw;
        logic        m2r;
        logic        pcs;
        string       name;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ret_model;
    vec_t tbl[17];
    vec_t lw_v;
    vec_t add_v;

    control_fsm_if #(.CNT_W(CNT_W)) bus ();

    control_fsm #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [11:0] cur();
        return {bus.loadPC, bus.PCSrc, bus.ALUSrc, bus.ALUCtrl,
                bus.RegWrite, bus.MemToReg, bus.MemRead, bus.MemWrite,
                bus.illegal};
    endfunction

    function automatic logic [11:0] exp_vec(input vec_t v, input int c,
                                            input int n);
        logic [11:0] e;
        e = '0;
        if (c >= 2) begin
            e[9]   = v.src;
            e[8:5] = v.alu;
        end
        if (n == 5 && c == 4) begin
            e[2] = v.rd;
            e[1] = v.wr;
        end
        if (c == n) begin
            e[11] = 1'b1;
            e[10] = v.pcs;
            e[4]  = v.rw;
            e[3]  = v.m2r;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        n = (v.rd || v.wr) ? 5 : 4;
        bus.instr = v.instr;
        bus.Zero  = v.zoth;
        for (int c = 1; c <= n; c++) begin
            chk($sformatf("%s cyc%0d", v.name, c), 32'(cur()),
                32'(exp_vec(v, c, n)));
            bus.Zero = (c == 3) ? v.zex : v.zoth;
            @(posedge clk);
            #1;
            bus.instr = $urandom();
        end
        ret_model = (ret_model + 1) % (1 << CNT_W);
        chk($sformatf("%s retired", v.name), 32'(bus.retired),
            32'(ret_model));
    endtask

    initial begin
        tbl[0]  = '{32'h002081B3, 0, 0, 4'b0010, 0, 0, 0, 1, 0, 0, "ADD"};
        tbl[1]  = '{32'h402081B3, 0, 0, 4'b0110, 0, 0, 0, 1, 0, 0, "SUB"};
        tbl[2]  = '{32'h0020C1B3, 0, 1, 4'b0101, 0, 0, 0, 1, 0, 0, "XOR"};
        tbl[3]  = '{32'h0020E1B3, 0, 0, 4'b0001, 0, 0, 0, 1, 0, 0, "OR"};
        tbl[4]  = '{32'h0020F1B3, 1, 0, 4'b0000, 0, 0, 0, 1, 0, 0, "AND"};
        tbl[5]  = '{32'h0020A1B3, 0, 0, 4'b0100, 0, 0, 0, 1, 0, 0, "SLT"};
        tbl[6]  = '{32'h002091B3, 0, 0, 4'b1001, 0, 0, 0, 1, 0, 0, "SLL"};
        tbl[7]  = '{32'h0020D1B3, 0, 0, 4'b1000, 0, 0, 0, 1, 0, 0, "SRL"};
        tbl[8]  = '{32'h4020D1B3, 0, 0, 4'b1010, 0, 0, 0, 1, 0, 0, "SRA"};
        tbl[9]  = '{32'h0000A183, 0, 0, 4'b0010, 1, 1, 0, 1, 1, 0, "LW"};
        tbl[10] = '{32'h0030A023, 0, 0, 4'b0010, 1, 0, 1, 0, 0, 0, "SW"};
        tbl[11] = '{32'h00208463, 1, 0, 4'b0110, 0, 0, 0, 0, 0, 1, "BEQ_T"};
        tbl[12] = '{32'h00208463, 0, 1, 4'b0110, 0, 0, 0, 0, 0, 0, "BEQ_N"};
        tbl[13] = '{32'h4020D193, 0, 0, 4'b1010, 1, 0, 0, 1, 0, 0, "SRAI"};
        tbl[14] = '{32'h0020D193, 0, 0, 4'b1000, 1, 0, 0, 1, 0, 0, "SRLI"};
        tbl[15] = '{32'h40208193, 0, 0, 4'b0010, 1, 0, 0, 1, 0, 0, "ADDI30"};
        tbl[16] = '{32'h0030A023, 1, 1, 4'b0010, 1, 0, 1, 0, 0, 0, "SW_Z"};
        lw_v  = tbl[9];
        add_v = tbl[0];

        checks    = 0;
        errors    = 0;
        ret_model = 0;
        rst       = 1'b0;
        bus.instr = 32'h0;
        bus.Zero  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold outs", 32'(cur()), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rel outs", 32'(cur()), 32'h0);
        chk("rst_rel retired", 32'(bus.retired), 32'h0);

        // 17 instructions with a 4-bit counter: wraps 15 -> 0 on the 16th
        foreach (tbl[i]) run_vec(tbl[i]);

        bus.instr = 32'h0;
        chk("ill cyc1", 32'(cur()), 32'h0);
        @(posedge clk);
        #1;
        chk("ill cyc2 strobes", 32'(cur() & 12'h817), 32'h0);
        @(posedge clk);
        #1;
        chk("ill cyc3", 32'(cur()), 32'h001);
        for (int k = 0; k < 20; k++) begin
            bus.instr = (k % 2 == 0) ? $urandom() : add_v.instr;
            bus.Zero  = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            chk($sformatf("ill hold%0d", k), 32'(cur()), 32'h001);
        end
        chk("ill retired", 32'(bus.retired), 32'(ret_model));
        #2;
        rst = 1'b0;
        #1;
        chk("ill async rst", 32'(cur()), 32'h0);
        chk("ill rst retired", 32'(bus.retired), 32'h0);
        ret_model = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        bus.instr = lw_v.instr;
        bus.Zero  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort MEM", 32'(cur()), 32'(exp_vec(lw_v, 4, 5)));
        #2;
        rst = 1'b0;
        #1;
        chk("abort async", 32'(cur()), 32'h0);
        @(posedge clk);
        #1;
        chk("abort hold", 32'(cur()), 32'h0);
        chk("abort retired", 32'(bus.retired), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        run_vec(add_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
